// File: rtl/dmem_unit.sv
// Byte-addressed little-endian data memory for the single-cycle core: clocked
// byte/half/word stores, combinational sign/zero-extended loads, sticky fault capture.
module dmem_unit #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memwrite,
  input  logic                  memread,
  input  logic [2:0]            memop,
  input  logic [ADDR_WIDTH-1:0] memaddr,
  input  logic [31:0]           memdatain,
  output logic [31:0]           memdataout,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] fault_addr,
  output logic [1:0]            fault_code,
  input  logic [ADDR_WIDTH-3:0] dbg_addr,
  output logic [31:0]           dbg_data
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  // Request semantics: memread/memwrite are single-cycle requests with no
  // handshake; a legal request is always accepted in the cycle it is presented.
  logic [31:0]           words [DEPTH];
  logic [ADDR_WIDTH-3:0] idx;
  logic [1:0]            lane;
  logic                  is_byte, is_half, is_word, op_ok;
  logic                  bad_op, misaligned, both, illegal;
  logic                  store_en, load_en;
  logic [1:0]            cause;
  logic [31:0]           rd_word, wdata, wmask, wr_word;
  logic [3:0]            be;
  logic [7:0]            byte_val;
  logic [15:0]           half_val;

  assign idx  = memaddr[ADDR_WIDTH-1:2];
  assign lane = memaddr[1:0];

  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    op_ok   = 1'b1;
    case (memop)
      3'b000, 3'b100: is_byte = 1'b1;
      3'b001, 3'b101: is_half = 1'b1;
      3'b010:         is_word = 1'b1;
      default:        op_ok   = 1'b0;
    endcase
  end

  // Unsigned variants (memop[2]) have no meaning for stores.
  assign bad_op     = !op_ok || (memwrite && memop[2]);
  assign misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));
  assign both       = memwrite && memread;
  assign illegal    = (memwrite || memread) && (both || bad_op || misaligned);
  assign store_en   = memwrite && !illegal;
  assign load_en    = memread && !illegal;

  always_comb begin
    if (both)        cause = 2'b11;
    else if (bad_op) cause = 2'b10;
    else             cause = 2'b01;
  end

  assign rd_word  = words[idx];
  assign dbg_data = words[dbg_addr];

  always_comb begin
    byte_val = rd_word[7:0];
    case (lane)
      2'd1:    byte_val = rd_word[15:8];
      2'd2:    byte_val = rd_word[23:16];
      2'd3:    byte_val = rd_word[31:24];
      default: byte_val = rd_word[7:0];
    endcase
  end

  assign half_val = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    memdataout = '0;
    if (load_en) begin
      if (is_byte)      memdataout = {{24{!memop[2] && byte_val[7]}}, byte_val};
      else if (is_half) memdataout = {{16{!memop[2] && half_val[15]}}, half_val};
      else              memdataout = rd_word;
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be    = 4'b1111;
    wdata = memdatain;
    if (is_byte) begin
      be    = 4'b0001 << lane;
      wdata = {4{memdatain[7:0]}};
    end else if (is_half) begin
      be    = lane[1] ? 4'b1100 : 4'b0011;
      wdata = {2{memdatain[15:0]}};
    end
  end

  assign wmask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wr_word = (rd_word & ~wmask) | (wdata & wmask);

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    logic [31:0] word_q;
    always_ff @(posedge clk) begin
      if (!rst) word_q <= '0;
      else if (store_en && (idx == (ADDR_WIDTH-2)'(w))) word_q <= wr_word;
    end
    assign words[w] = word_q;
  end

  // Only the first illegal access since reset is recorded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fault      <= 1'b0;
      fault_addr <= '0;
      fault_code <= 2'b00;
    end else if (illegal && !fault) begin
      fault      <= 1'b1;
      fault_addr <= memaddr;
      fault_code <= cause;
    end
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Directed bench for dmem_unit: driver pushes expected values, a negedge monitor
// pops and compares them against the DUT outputs.
module tb_dmem_unit;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_X  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam int S_OUT = 0;
  localparam int S_DBG = 1;
  localparam int S_FLT = 2;
  localparam int S_FA  = 3;
  localparam int S_FC  = 4;

  logic        clk;
  logic        rst;
  logic        memwrite;
  logic        memread;
  logic [2:0]  memop;
  logic [8:0]  memaddr;
  logic [31:0] memdatain;
  logic [31:0] memdataout;
  logic        fault;
  logic [8:0]  fault_addr;
  logic [1:0]  fault_code;
  logic [6:0]  dbg_addr;
  logic [31:0] dbg_data;

  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  dmem_unit #(.ADDR_WIDTH(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .memwrite   (memwrite),
    .memread    (memread),
    .memop      (memop),
    .memaddr    (memaddr),
    .memdatain  (memdatain),
    .memdataout (memdataout),
    .fault      (fault),
    .fault_addr (fault_addr),
    .fault_code (fault_code),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic drive(input logic r, input logic w, input logic rd, input logic [2:0] op,
                       input logic [8:0] a, input logic [31:0] d, input logic [6:0] da);
    @(posedge clk);
    #1;
    rst       = r;
    memwrite  = w;
    memread   = rd;
    memop     = op;
    memaddr   = a;
    memdatain = d;
    dbg_addr  = da;
  endtask

  task automatic chk(input int sel, input logic [31:0] e, input string n);
    exp_q.push_back(e);
    sel_q.push_back(sel);
    name_q.push_back(n);
  endtask

  task automatic chk_fault(input logic f, input logic [8:0] a, input logic [1:0] c, input string n);
    chk(S_FLT, {31'b0, f}, {n, "_fault"});
    chk(S_FA,  {23'b0, a}, {n, "_faddr"});
    chk(S_FC,  {30'b0, c}, {n, "_fcode"});
  endtask

  // scoreboard monitor
  initial begin
    logic [31:0] e;
    logic [31:0] act;
    int          s;
    string       n;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        s = sel_q.pop_front();
        n = name_q.pop_front();
        case (s)
          S_OUT:   act = memdataout;
          S_DBG:   act = dbg_data;
          S_FLT:   act = {31'b0, fault};
          S_FA:    act = {23'b0, fault_addr};
          default: act = {30'b0, fault_code};
        endcase
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", n, act, e);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst = 1'b0; memwrite = 1'b0; memread = 1'b0; memop = OP_W;
    memaddr = '0; memdatain = '0; dbg_addr = '0;

    drive(0, 0, 0, OP_W, 9'h000, 32'h0, 7'd0);
    drive(1, 0, 0, OP_W, 9'h000, 32'h0, 7'd0);
    chk(S_OUT, 32'h0, "rst_out");
    chk_fault(1'b0, 9'h000, 2'b00, "rst");
    chk(S_DBG, 32'h0, "rst_dbg0");
    drive(1, 0, 0, OP_W, 9'h000, 32'h0, 7'd4);   chk(S_DBG, 32'h0, "rst_dbg4");
    drive(1, 0, 0, OP_W, 9'h000, 32'h0, 7'd127); chk(S_DBG, 32'h0, "rst_dbg127");

    // word store / load round trip
    drive(1, 1, 0, OP_W, 9'h010, 32'hDEADBEEF, 7'd4);
    chk(S_DBG, 32'h0, "sw_prestore_dbg");
    chk(S_OUT, 32'h0, "sw_out_zero");
    drive(1, 0, 1, OP_W, 9'h010, 32'h0, 7'd4);
    chk(S_OUT, 32'hDEADBEEF, "lw_out");
    chk(S_DBG, 32'hDEADBEEF, "lw_dbg");

    // byte and half lanes
    drive(1, 1, 0, OP_B, 9'h013, 32'h000000AA, 7'd4);
    drive(1, 0, 1, OP_B, 9'h013, 32'h0, 7'd4);
    chk(S_OUT, 32'hFFFFFFAA, "lb_out");
    chk(S_DBG, 32'hAAADBEEF, "sb_dbg");
    drive(1, 0, 1, OP_BU, 9'h013, 32'h0, 7'd4);  chk(S_OUT, 32'h000000AA, "lbu_out");
    drive(1, 1, 0, OP_H, 9'h010, 32'h00001234, 7'd4);
    drive(1, 0, 1, OP_H, 9'h012, 32'h0, 7'd4);
    chk(S_OUT, 32'hFFFFAAAD, "lh_out");
    chk(S_DBG, 32'hAAAD1234, "sh_dbg");
    drive(1, 0, 1, OP_HU, 9'h012, 32'h0, 7'd4);
    chk(S_OUT, 32'h0000AAAD, "lhu_out");
    chk(S_FLT, 32'h0, "legal_nofault");

    // misaligned store, then a second fault that must not overwrite
    drive(1, 1, 0, OP_W, 9'h022, 32'h11111111, 7'd8);
    chk(S_FLT, 32'h0, "mis_pre_fault");
    drive(1, 0, 1, OP_H, 9'h005, 32'h0, 7'd8);
    chk(S_OUT, 32'h0, "mis_lh_out");
    chk(S_DBG, 32'h0, "mis_word8");
    chk_fault(1'b1, 9'h022, 2'b01, "mis");
    drive(1, 0, 1, OP_W, 9'h010, 32'h0, 7'd8);
    chk(S_OUT, 32'hAAAD1234, "lw_after_fault");
    chk_fault(1'b1, 9'h022, 2'b01, "mis_sticky");

    // bad memop on load
    drive(0, 0, 0, OP_W, 9'h000, 32'h0, 7'd0);
    drive(1, 0, 1, OP_X, 9'h010, 32'h0, 7'd4);
    chk(S_OUT, 32'h0, "badop_out");
    chk(S_DBG, 32'h0, "badop_rst_dbg");
    chk(S_FLT, 32'h0, "badop_pre");
    drive(1, 0, 0, OP_W, 9'h000, 32'h0, 7'd4);
    chk_fault(1'b1, 9'h010, 2'b10, "badop");

    // read and write together
    drive(0, 0, 0, OP_W, 9'h000, 32'h0, 7'd0);
    drive(1, 1, 0, OP_W, 9'h040, 32'h55AA55AA, 7'd16);
    drive(1, 1, 1, OP_W, 9'h040, 32'hFFFFFFFF, 7'd16);
    chk(S_OUT, 32'h0, "rw_out");
    drive(1, 0, 0, OP_W, 9'h000, 32'h0, 7'd16);
    chk(S_DBG, 32'h55AA55AA, "rw_word16");
    chk_fault(1'b1, 9'h040, 2'b11, "rw");

    // unsigned op on a store is illegal
    drive(0, 0, 0, OP_W, 9'h000, 32'h0, 7'd0);
    drive(1, 1, 0, OP_BU, 9'h041, 32'h00000077, 7'd16);
    drive(1, 0, 0, OP_W, 9'h000, 32'h0, 7'd16);
    chk(S_DBG, 32'h0, "sbu_word16");
    chk_fault(1'b1, 9'h041, 2'b10, "sbu");

    // reset mid-stream discards the concurrent store and clears the fault
    drive(0, 0, 0, OP_W, 9'h000, 32'h0, 7'd0);
    drive(1, 1, 0, OP_W, 9'h1FC, 32'hCAFEF00D, 7'd127);
    chk(S_DBG, 32'h0, "top_prestore");
    drive(1, 0, 1, OP_W, 9'h1FD, 32'h0, 7'd127);
    chk(S_OUT, 32'h0, "top_mis_out");
    chk(S_DBG, 32'hCAFEF00D, "top_store");
    drive(0, 1, 0, OP_W, 9'h1FC, 32'h99999999, 7'd127);
    chk_fault(1'b1, 9'h1FD, 2'b01, "top_mis");
    drive(1, 0, 0, OP_W, 9'h000, 32'h0, 7'd127);
    chk(S_DBG, 32'h0, "midrst_word127");
    chk_fault(1'b0, 9'h000, 2'b00, "midrst");

    // top word round trip, no wrap into word 0
    drive(1, 1, 0, OP_W, 9'h1FC, 32'h01020304, 7'd0);
    drive(1, 0, 1, OP_W, 9'h1FC, 32'h0, 7'd0);
    chk(S_OUT, 32'h01020304, "top_lw");
    chk(S_DBG, 32'h0, "top_nowrap");
    drive(1, 1, 0, OP_B, 9'h1FD, 32'hFFFFFF80, 7'd127);
    drive(1, 0, 1, OP_B, 9'h1FD, 32'h0, 7'd127);
    chk(S_OUT, 32'hFFFFFF80, "top_lb");
    chk(S_DBG, 32'h01028004, "top_sb_dbg");
    drive(1, 0, 1, OP_H, 9'h1FC, 32'h0, 7'd127);  chk(S_OUT, 32'hFFFF8004, "top_lh");
    drive(1, 0, 1, OP_HU, 9'h1FE, 32'h0, 7'd127); chk(S_OUT, 32'h00000102, "top_lhu");
    drive(1, 0, 1, OP_BU, 9'h1FF, 32'h0, 7'd127); chk(S_OUT, 32'h00000001, "top_lbu");
    chk(S_FLT, 32'h0, "top_nofault");

    drive(1, 0, 0, OP_W, 9'h000, 32'h0, 7'd0);
    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
